// File: rtl/ula_pkg.sv
// ula_pkg: shared types and widths for the ULA arbiter slice.
//   ula_req_t   - one requester operation (operands, operacao, modo)
//   ula_rsp_t   - sampled ULA outputs returned to the winning requester
//   arb_state_t - sequencer states
package ula_pkg;

   localparam int ULA_W = 6;
   localparam int OP_W  = 3;

   typedef struct packed {
      logic [ULA_W-1:0] a;
      logic [ULA_W-1:0] b;
      logic [OP_W-1:0]  op;
      logic             modo;
   } ula_req_t;

   typedef struct packed {
      logic [ULA_W-1:0] result;
      logic             overflow;
      logic             zero;
   } ula_rsp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant.
//   valid[1:0]  in  requester valids
//   last_grant  in  index of the requester served most recently
//   grant[1:0]  out one-hot grant (all zero when nobody is valid)
// A lone requester always wins; on contention the requester that was
// not served last wins, so continuous contention alternates strictly.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin arbiter and sequencer in front of a single ULA.
//   CLOCK_50 / reset          clock, asynchronous active-high reset
//   reqN_valid/ready          valid/ready handshake per requester (N = 0,1)
//   reqN_a/b/op/modo          operation payload per requester
//   respN_valid               one-cycle pulse marking whose response is on resp_*
//   resp_result/overflow/zero sampled ULA outputs, held until the next sample
//   alu_a/b/op/modo           registered operands/control driven to the ULA
//   alu_resultado/overflow/zero  ULA outputs
//   busy                      high whenever the sequencer is not IDLE
// Sequence per operation: IDLE (transfer) -> RUN for ALU_LAT+1 cycles ->
// RESP (pulse) -> IDLE, i.e. one operation every ALU_LAT+3 cycles.
module ula_arbiter
   import ula_pkg::*;
#(
   parameter int ALU_LAT = 3
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [ULA_W-1:0] req0_a,
   input  logic [ULA_W-1:0] req0_b,
   input  logic [OP_W-1:0]  req0_op,
   input  logic             req0_modo,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [ULA_W-1:0] req1_a,
   input  logic [ULA_W-1:0] req1_b,
   input  logic [OP_W-1:0]  req1_op,
   input  logic             req1_modo,
   output logic             resp0_valid,
   output logic             resp1_valid,
   output logic [ULA_W-1:0] resp_result,
   output logic             resp_overflow,
   output logic             resp_zero,
   output logic [ULA_W-1:0] alu_a,
   output logic [ULA_W-1:0] alu_b,
   output logic [OP_W-1:0]  alu_op,
   output logic             alu_modo,
   input  logic [ULA_W-1:0] alu_resultado,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   output logic             busy
);

   localparam int CNT_W = 3;

   arb_state_t       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic [1:0]       grant;
   logic             xfer;
   ula_req_t         req0, req1, sel_req, alu_q;
   ula_rsp_t         rsp_q;

   assign req0 = '{a: req0_a, b: req0_b, op: req0_op, modo: req0_modo};
   assign req1 = '{a: req1_a, b: req1_b, op: req1_op, modo: req1_modo};

   rr_arbiter2 u_rr (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Ready is only offered in IDLE, so a grant outside IDLE never transfers.
   assign req0_ready = (state == IDLE) & grant[0];
   assign req1_ready = (state == IDLE) & grant[1];
   assign xfer       = req0_ready | req1_ready;
   assign sel_req    = grant[1] ? req1 : req0;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (xfer) state_next = RUN;
         RUN:     if (cnt == '0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand latch, wait counter, response sample and pulse.
   // cnt starts at ALU_LAT so RUN lasts ALU_LAT+1 cycles; the sample is
   // taken on the cycle where cnt has reached zero.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         alu_q       <= '0;
         rsp_q       <= '0;
         cnt         <= '0;
         last_grant  <= 1'b1;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
      end else begin
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer) begin
                  alu_q      <= sel_req;
                  last_grant <= grant[1];
                  cnt        <= CNT_W'(ALU_LAT);
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_q       <= '{result: alu_resultado, overflow: alu_overflow,
                                   zero: alu_zero};
                  resp0_valid <= ~last_grant;
                  resp1_valid <= last_grant;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_a         = alu_q.a;
   assign alu_b         = alu_q.b;
   assign alu_op        = alu_q.op;
   assign alu_modo      = alu_q.modo;
   assign resp_result   = rsp_q.result;
   assign resp_overflow = rsp_q.overflow;
   assign resp_zero     = rsp_q.zero;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed bench for ula_arbiter with a 3-cycle behavioural
// ULA, a scoreboard of expected responses filled at each transfer, and
// invariant checks on ready/alu stability.
module tb_ula_arbiter;
   import ula_pkg::*;

   localparam int ALU_LAT = 3;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [5:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic       req0_modo = 1'b0, req1_modo = 1'b0;
   logic       resp0_valid, resp1_valid;
   logic [5:0] resp_result;
   logic       resp_overflow, resp_zero;
   logic [5:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic       alu_modo;
   logic [5:0] alu_resultado;
   logic       alu_overflow, alu_zero;
   logic       busy;

   always #10 CLOCK_50 = ~CLOCK_50;

   ula_arbiter #(.ALU_LAT(ALU_LAT)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_op(req0_op), .req0_modo(req0_modo),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_op(req1_op), .req1_modo(req1_modo),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
      .resp_result(resp_result), .resp_overflow(resp_overflow), .resp_zero(resp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_modo(alu_modo),
      .alu_resultado(alu_resultado), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .busy(busy)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural ULA: returns {overflow, zero, result}. Arithmetic overflow
   // is the unsigned carry/borrow out of bit 5.
   function automatic logic [7:0] ula_f(input logic [5:0] a, input logic [5:0] b,
                                         input logic [2:0] op, input logic modo);
      logic [6:0] s;
      logic [5:0] r;
      logic       o;
      s = {1'b0, a};
      r = a;
      o = 1'b0;
      if (!modo) begin
         case (op)
            3'd0:    s = {1'b0, a} + {1'b0, b};
            3'd1:    s = {1'b0, a} - {1'b0, b};
            3'd2:    s = {1'b0, a} + 7'd1;
            3'd3:    s = {1'b0, a} - 7'd1;
            default: s = {1'b0, a};
         endcase
         r = s[5:0];
         o = s[6];
      end else begin
         case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~a;
            default: r = a;
         endcase
      end
      return {o, (r == 6'd0), r};
   endfunction

   // ULA pipeline: output reflects alu_* inputs ALU_LAT cycles later.
   logic [7:0] p1 = '0, p2 = '0, p3 = '0;
   always @(posedge CLOCK_50) begin
      p1 <= ula_f(alu_a, alu_b, alu_op, alu_modo);
      p2 <= p1;
      p3 <= p2;
   end
   assign alu_resultado = p3[5:0];
   assign alu_zero      = p3[6];
   assign alu_overflow  = p3[7];

   typedef struct {
      bit         who;
      logic [5:0] r;
      logic       o;
      logic       z;
   } exp_t;

   exp_t sb[$];
   exp_t e_pop;

   function automatic exp_t mk(input bit who, input logic [5:0] a, input logic [5:0] b,
                               input logic [2:0] op, input logic modo);
      logic [7:0] f;
      exp_t e;
      f = ula_f(a, b, op, modo);
      e.who = who;
      e.r = f[5:0];
      e.z = f[6];
      e.o = f[7];
      return e;
   endfunction

   // Monitor: scoreboard push on transfer, pop/compare on response pulse.
   logic        busy_d = 1'b0;
   logic [15:0] alu_d  = '0;
   always @(negedge CLOCK_50) begin
      if (!reset) begin
         if (req0_valid && req0_ready) sb.push_back(mk(1'b0, req0_a, req0_b, req0_op, req0_modo));
         if (req1_valid && req1_ready) sb.push_back(mk(1'b1, req1_a, req1_b, req1_op, req1_modo));
         if (busy) check("ready_outside_idle", {30'd0, req1_ready, req0_ready}, 32'd0);
         if (busy && busy_d) check("alu_stable", {alu_a, alu_b, alu_op, alu_modo}, alu_d);
         if (resp0_valid || resp1_valid) begin
            check("resp_onehot", resp0_valid & resp1_valid, 0);
            if (sb.size() == 0) begin
               check("resp_unexpected", {30'd0, resp1_valid, resp0_valid}, 32'd0);
            end else begin
               e_pop = sb.pop_front();
               check("resp_who", resp1_valid, e_pop.who);
               check("resp_result", resp_result, e_pop.r);
               check("resp_overflow", resp_overflow, e_pop.o);
               check("resp_zero", resp_zero, e_pop.z);
            end
         end
      end
      busy_d <= busy;
      alu_d  <= {alu_a, alu_b, alu_op, alu_modo};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_ready(input int who, output int c, output bit ok);
      ok = 0;
      c  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLOCK_50);
         if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin
            ok = 1;
            c  = cyc;
            return;
         end
      end
   endtask

   task automatic wait_any(output int who, output int c, output bit ok);
      ok = 0;
      c = 0;
      who = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLOCK_50);
         if (req0_ready || req1_ready) begin
            ok = 1;
            c = cyc;
            who = req1_ready ? 1 : 0;
            return;
         end
      end
   endtask

   task automatic wait_resp(output int c, output bit ok);
      ok = 0;
      c = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLOCK_50);
         if (resp0_valid || resp1_valid) begin
            ok = 1;
            c = cyc;
            return;
         end
      end
   endtask

   initial begin
      int  t0, c, who, prev;
      bit  ok;

      // Reset state
      repeat (2) @(negedge CLOCK_50);
      check("rst_alu", {alu_a, alu_b, alu_op, alu_modo}, 0);
      check("rst_busy", busy, 0);
      check("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
      check("rst_resp", {resp_result, resp_overflow, resp_zero}, 0);

      // 1: single req0 add 5+3
      tick;
      reset = 1'b0;
      req0_valid = 1; req0_a = 6'd5; req0_b = 6'd3; req0_op = 3'd0; req0_modo = 0;
      @(negedge CLOCK_50);
      check("t1_ready0_first", req0_ready, 1);
      check("t1_ready1", req1_ready, 0);
      t0 = cyc;
      tick;
      req0_valid = 0;
      check("t1_busy", busy, 1);
      wait_resp(c, ok);
      check("t1_resp_seen", ok, 1);
      check("t1_latency", c - t0, ALU_LAT + 2);
      check("t1_resp0", resp0_valid, 1);
      check("t1_result", {resp_result, resp_overflow, resp_zero}, {6'd8, 1'b0, 1'b0});
      tick;

      // 2: contention after reset (last_grant=1 -> req0 first)
      reset = 1'b1;
      tick;
      reset = 1'b0;
      req0_valid = 1; req0_a = 6'd63; req0_b = 6'd1; req0_op = 3'd0; req0_modo = 0;
      req1_valid = 1; req1_a = 6'd12; req1_b = 6'd10; req1_op = 3'd0; req1_modo = 1;
      @(negedge CLOCK_50);
      check("t2_grant0", {req1_ready, req0_ready}, 2'b01);
      tick;
      req0_valid = 0;
      wait_resp(c, ok);
      check("t2_resp0_seen", ok, 1);
      check("t2_resp0", {resp1_valid, resp0_valid}, 2'b01);
      check("t2_result0", {resp_result, resp_overflow, resp_zero}, {6'd0, 1'b1, 1'b1});
      wait_ready(1, c, ok);
      check("t2_ready1_seen", ok, 1);
      tick;
      req1_valid = 0;
      wait_resp(c, ok);
      check("t2_resp1_seen", ok, 1);
      check("t2_resp1", {resp1_valid, resp0_valid}, 2'b10);
      check("t2_result1", resp_result, 8);
      tick;

      // 3: continuous contention, strict alternation every ALU_LAT+3 cycles
      req0_valid = 1; req0_a = 6'($urandom); req0_b = 6'($urandom);
      req0_op = 3'($urandom); req0_modo = 1'($urandom);
      req1_valid = 1; req1_a = 6'($urandom); req1_b = 6'($urandom);
      req1_op = 3'($urandom); req1_modo = 1'($urandom);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_any(who, c, ok);
         check("t3_xfer_seen", ok, 1);
         check("t3_grant_order", who, i % 2);
         if (i > 0) check("t3_spacing", c - prev, ALU_LAT + 3);
         prev = c;
         tick;
         if (i == 3) begin
            req0_valid = 0;
            req1_valid = 0;
         end else if (who == 0) begin
            req0_a = 6'($urandom); req0_b = 6'($urandom);
            req0_op = 3'($urandom); req0_modo = 1'($urandom);
         end else begin
            req1_a = 6'($urandom); req1_b = 6'($urandom);
            req1_op = 3'($urandom); req1_modo = 1'($urandom);
         end
      end
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLOCK_50);
      check("t3_drain", sb.size(), 0);
      tick;

      // 4 + 6: reset two cycles into RUN, then lone req1 with last_grant=1
      req0_valid = 1; req0_a = 6'd7; req0_b = 6'd9; req0_op = 3'd0; req0_modo = 0;
      wait_ready(0, c, ok);
      check("t4_ready0", ok, 1);
      tick;
      req0_valid = 0;
      tick;
      check("t4_alu_before", alu_a, 7);
      reset = 1'b1;
      #1;
      check("t4_rst_alu", {alu_a, alu_b, alu_op, alu_modo}, 0);
      check("t4_rst_busy", busy, 0);
      check("t4_rst_resp", {resp_result, resp_overflow, resp_zero, resp1_valid, resp0_valid}, 0);
      sb.delete();
      tick;
      reset = 1'b0;
      req1_valid = 1; req1_a = 6'd20; req1_b = 6'd22; req1_op = 3'd1; req1_modo = 1;
      @(negedge CLOCK_50);
      check("t6_lone_req1", {req1_ready, req0_ready}, 2'b10);
      t0 = cyc;
      tick;
      req1_valid = 0;
      wait_resp(c, ok);
      check("t4_resp_seen", ok, 1);
      check("t4_first_resp_is_req1", {resp1_valid, resp0_valid}, 2'b10);
      check("t4_latency", c - t0, ALU_LAT + 2);
      check("t4_result", resp_result, 22);
      tick;

      // 5: req1 arrives during RESP of a req0 operation
      req0_valid = 1; req0_a = 6'd30; req0_b = 6'd2; req0_op = 3'd1; req0_modo = 0;
      wait_ready(0, c, ok);
      check("t5_ready0", ok, 1);
      tick;
      req0_valid = 0;
      repeat (4) tick;
      req1_valid = 1; req1_a = 6'd33; req1_b = 6'd17; req1_op = 3'd2; req1_modo = 1;
      @(negedge CLOCK_50);
      check("t5_in_resp", resp0_valid, 1);
      check("t5_result0", resp_result, 28);
      check("t5_ready1_blocked", req1_ready, 0);
      tick;
      @(negedge CLOCK_50);
      check("t5_ready1_idle", req1_ready, 1);
      tick;
      req1_valid = 0;
      check("t5_alu_captured", {alu_a, alu_b, alu_op, alu_modo}, {6'd33, 6'd17, 3'd2, 1'b1});
      wait_resp(c, ok);
      check("t5_resp1_seen", ok, 1);
      check("t5_result1", {resp1_valid, resp_result}, {1'b1, 6'd48});
      tick;
      check("t5_drain", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
